// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver.
// Strips E0/F0 prefixes into flags and latches each completed key frame.
module ps2_receiver #(
  parameter logic [7:0] EXTENDED_BYTE = 8'hE0,
  parameter logic [7:0] RELEASE_BYTE  = 8'hF0
) (
  input  logic        ps2_clk,
  input  logic        rst,
  input  logic        ps2_data,
  output logic [10:0] data,
  output logic        data_latch,
  output logic        reset_required,
  output logic        release_key,
  output logic        extended_code
);

  logic [3:0]  r_cnt;
  logic [10:0] r_shift;
  logic        r_pend_rel;
  logic        r_pend_ext;
  logic [10:0] r_data;
  logic        r_latch;
  logic        r_err;
  logic        r_rel;
  logic        r_ext;

  logic [10:0] w_frame;
  logic [7:0]  w_byte;
  logic        w_valid;
  logic        w_is_rel;
  logic        w_is_ext;

  // The stop bit is still on the line at the completing edge.
  assign w_frame  = {ps2_data, r_shift[9:0]};
  assign w_byte   = w_frame[8:1];
  assign w_valid  = ~w_frame[0] & w_frame[10]
                  & (^w_frame[9:1]);
  assign w_is_rel = (w_byte == RELEASE_BYTE);
  assign w_is_ext = (w_byte == EXTENDED_BYTE);

  // Bit counter, shifter, prefix tracking and output registers.
  always_ff @(negedge ps2_clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= 4'd0;
      r_shift    <= 11'd0;
      r_pend_rel <= 1'b0;
      r_pend_ext <= 1'b0;
      r_data     <= 11'd0;
      r_latch    <= 1'b0;
      r_err      <= 1'b0;
      r_rel      <= 1'b0;
      r_ext      <= 1'b0;
    end else begin
      unique case (1'b1)
        (r_cnt == 4'd0): begin
          if (!ps2_data) begin
            r_shift[0] <= ps2_data;
            r_cnt      <= 4'd1;
            r_latch    <= 1'b0;
            r_rel      <= 1'b0;
            r_ext      <= 1'b0;
          end
        end
        (r_cnt == 4'd10): begin
          r_shift[10] <= ps2_data;
          r_cnt       <= 4'd0;
          if (!w_valid) begin
            r_err      <= 1'b1;
            r_pend_rel <= 1'b0;
            r_pend_ext <= 1'b0;
          end else if (w_is_rel) begin
            r_pend_rel <= 1'b1;
          end else if (w_is_ext) begin
            r_pend_ext <= 1'b1;
          end else begin
            r_data     <= w_frame;
            r_latch    <= 1'b1;
            r_rel      <= r_pend_rel;
            r_ext      <= r_pend_ext;
            r_pend_rel <= 1'b0;
            r_pend_ext <= 1'b0;
          end
        end
        default: begin
          r_shift[r_cnt] <= ps2_data;
          r_cnt          <= r_cnt + 4'd1;
        end
      endcase
    end
  end

  assign data           = r_data;
  assign data_latch     = r_latch;
  assign reset_required = r_err;
  assign release_key    = r_rel;
  assign extended_code  = r_ext;

endmodule

// File: tb/tb_ps2_receiver.sv
// Bench for ps2_receiver: directed frames then random
// frames checked against a frame-level reference model.
module tb_ps2_receiver;

  logic        ps2_clk;
  logic        rst;
  logic        ps2_data;
  logic [10:0] data;
  logic        data_latch;
  logic        reset_required;
  logic        release_key;
  logic        extended_code;

  int n_cmp;
  int n_bad;

  // Reference model state, updated once per frame.
  logic [10:0] m_data;
  logic        m_latch;
  logic        m_rr;
  logic        m_rel;
  logic        m_ext;
  logic        m_prel;
  logic        m_pext;

  ps2_receiver dut (
    .ps2_clk        (ps2_clk),
    .rst            (rst),
    .ps2_data       (ps2_data),
    .data           (data),
    .data_latch     (data_latch),
    .reset_required (reset_required),
    .release_key    (release_key),
    .extended_code  (extended_code)
  );

  task automatic chk(input string tag,
                     input logic [10:0] obs,
                     input logic [10:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data  = '0;
    m_latch = 0;
    m_rr    = 0;
    m_rel   = 0;
    m_ext   = 0;
    m_prel  = 0;
    m_pext  = 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".data"}, data, m_data);
    chk({tag, ".latch"}, {10'd0, data_latch},
        {10'd0, m_latch});
    chk({tag, ".rr"}, {10'd0, reset_required},
        {10'd0, m_rr});
    chk({tag, ".rel"}, {10'd0, release_key},
        {10'd0, m_rel});
    chk({tag, ".ext"}, {10'd0, extended_code},
        {10'd0, m_ext});
  endtask

  // One falling then rising edge; data changes while clk high.
  task automatic edge_bit(input logic b);
    ps2_data = b;
    #20 ps2_clk = 0;
    #20 ps2_clk = 1;
  endtask

  // Sends a frame for byte b, optionally corrupting
  // parity or stop, and advances the model.
  task automatic send_frame(input logic [7:0] b,
                            input bit bad_par,
                            input bit bad_stop,
                            input string tag);
    logic [10:0] f;
    logic        par;
    par = (~^b) ^ bad_par;
    f = {~bad_stop, par, b, 1'b0};
    edge_bit(f[0]);
    m_latch = 0;
    m_rel   = 0;
    m_ext   = 0;
    chk({tag, ".start_clr"}, {8'd0, data_latch,
        release_key, extended_code}, 11'd0);
    for (int i = 1; i < 10; i++) edge_bit(f[i]);
    chk({tag, ".pre_stop"}, {10'd0, data_latch},
        11'd0);
    edge_bit(f[10]);
    if (bad_par || bad_stop) begin
      m_rr   = 1;
      m_prel = 0;
      m_pext = 0;
    end else if (b == 8'hF0) begin
      m_prel = 1;
    end else if (b == 8'hE0) begin
      m_pext = 1;
    end else begin
      m_data  = f;
      m_latch = 1;
      m_rel   = m_prel;
      m_ext   = m_pext;
      m_prel  = 0;
      m_pext  = 0;
    end
    chk_all(tag);
  endtask

  task automatic do_reset();
    #7 rst = 1;
    #13 rst = 0;
    #5;
    model_reset();
  endtask

  initial begin
    logic [7:0] b;
    int r;
    n_cmp    = 0;
    n_bad    = 0;
    ps2_clk  = 1;
    ps2_data = 1;
    rst      = 1;
    model_reset();
    #30;
    chk_all("reset");
    rst = 0;
    #20;

    send_frame(8'h1C, 0, 0, "k1C");
    chk("k1C.const", data, 11'h438);

    send_frame(8'hF0, 0, 0, "F0");
    chk("F0.nolatch", {10'd0, data_latch}, 11'd0);
    send_frame(8'h1C, 0, 0, "rel1C");
    chk("rel1C.const", {data, release_key,
        extended_code} & 11'h7FF, {11'h438, 2'b10} & 11'h7FF);
    chk("rel1C.data", data, 11'h438);

    send_frame(8'hE0, 0, 0, "E0");
    send_frame(8'h75, 0, 0, "ext75");
    chk("ext75.const", data, 11'h4EA);

    send_frame(8'hE0, 0, 0, "E0b");
    send_frame(8'hF0, 0, 0, "F0b");
    send_frame(8'h75, 0, 0, "both75");
    chk("both75.flags", {9'd0, release_key,
        extended_code}, 11'd3);
    send_frame(8'h1C, 0, 0, "after1C");

    send_frame(8'hF0, 0, 0, "F0c");
    send_frame(8'hE0, 0, 0, "E0c");
    send_frame(8'h1C, 0, 0, "rev1C");

    send_frame(8'h1C, 1, 0, "badpar");
    chk("badpar.rr", {10'd0, reset_required}, 11'd1);
    send_frame(8'h1C, 0, 1, "badstop");
    send_frame(8'h1C, 0, 0, "good_after_err");
    chk("gae.data", data, 11'h438);

    for (int i = 0; i < 5; i++) edge_bit(i == 0 ? 1'b0 : 1'b1);
    do_reset();
    chk_all("midrst");
    send_frame(8'h1C, 0, 0, "postrst");
    chk("postrst.data", data, 11'h438);

    for (int n = 0; n < 60; n++) begin
      if (n == 30) begin
        do_reset();
        chk_all("rnd_rst");
      end
      r = int'($urandom_range(0, 9));
      b = 8'($urandom);
      if (r < 2) b = 8'hE0;
      else if (r < 4) b = 8'hF0;
      for (int k = int'($urandom_range(0, 2)); k > 0; k--)
        edge_bit(1'b1);
      r = int'($urandom_range(0, 11));
      send_frame(b, r == 0, r == 1, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
